// File: rtl/hazard_scoreboard.sv
// Hazard unit for the pipelined CPU. A shadow record of in-flight register writers
// (EX..WB) drives the stall/bubble controls, the forwarding selects and a stall counter.
module hazard_scoreboard #(
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 3,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16,
    localparam int FSEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regw,
    input  logic                id_load,
    input  logic                flush,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                hazard_mux,
    output logic                stall,
    output logic [FSEL_W-1:0]   fwd_a,
    output logic [FSEL_W-1:0]   fwd_b,
    output logic [CNT_W-1:0]    stall_count
);

    // Slot 1 = EX ... slot DEPTH = WB
    logic                v_reg  [1:DEPTH];
    logic [REG_BITS-1:0] rd_reg [1:DEPTH];
    logic                ld_reg [1:DEPTH];
    logic [CNT_W-1:0]    stall_count_reg;

    logic [DEPTH:1]      match_a;
    logic [DEPTH:1]      match_b;
    logic [FSEL_W-1:0]   sel_a;
    logic [FSEL_W-1:0]   sel_b;
    logic                hazard;
    logic                kill;
    logic                new_v;

    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_match
        assign match_a[gi] = v_reg[gi] && (rd_reg[gi] == id_rs) && (id_rs != '0);
        assign match_b[gi] = v_reg[gi] && (rd_reg[gi] == id_rt) && (id_rt != '0);
    end

    // Scan oldest to youngest so the smallest matching slot index is left standing.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match_a[k]) sel_a = FSEL_W'(k);
            if (match_b[k]) sel_b = FSEL_W'(k);
        end
    end

    if (FWD_EN != 0) begin : g_fwd_mode
        // Only a load still in EX cannot be forwarded from.
        assign hazard = id_valid && ld_reg[1] &&
                        ((sel_a == FSEL_W'(1)) || (sel_b == FSEL_W'(1)));
    end else begin : g_stall_mode
        assign hazard = id_valid && ((|match_a) || (|match_b));
    end

    assign kill       = reset || flush;
    assign stall      = hazard && !kill;
    assign pc_write   = !stall;
    assign ifid_write = !stall;
    assign hazard_mux = stall;
    assign fwd_a      = ((FWD_EN != 0) && !kill) ? sel_a : '0;
    assign fwd_b      = ((FWD_EN != 0) && !kill) ? sel_b : '0;

    assign new_v       = id_valid && id_regw && (id_rd != '0) && !stall;
    assign stall_count = stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) v_reg[k] <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            if (flush) begin
                for (int k = 1; k <= DEPTH; k++) v_reg[k] <= 1'b0;
            end else begin
                for (int k = DEPTH; k >= 2; k--) begin
                    v_reg[k]  <= v_reg[k-1];
                    rd_reg[k] <= rd_reg[k-1];
                    ld_reg[k] <= ld_reg[k-1];
                end
                v_reg[1]  <= new_v;
                rd_reg[1] <= id_rd;
                ld_reg[1] <= id_load;
            end
            if (stall && (stall_count_reg != {CNT_W{1'b1}}))
                stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

endmodule
